knn_vote: RTL and testbench

Downstream consumer of the distance sort network in the KNN classifier. Accepts the sorted (distance, class type) stream, lowest distance first. Counts class votes among the first K beats and returns the winning class with its vote count and nearest distance. One classification per stream, delivered with a valid/ready output handshake.

---
 rtl/knn_pkg.sv | 17 +
 rtl/knn_class_tally.sv | 43 ++++
 rtl/knn_vote.sv | 172 +++++++++++++++++
 tb/tb_knn_vote.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared definitions for the KNN classifier back end: default widths,
// the vote FSM state encoding and the class identifier type.
package knn_pkg;

    localparam int W_DEF      = 16;
    localparam int TYPE_W_DEF = 3;
    localparam int K_DEF      = 5;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        TALLY   = 2'd1,
        HOLD    = 2'd2
    } state_t;

    typedef logic [TYPE_W_DEF-1:0] class_t;

endpackage

// File: rtl/knn_class_tally.sv
// Per-class vote counters and first-seen ranks, with one update port
// driven by accepted beats and one combinational read port for the scan.
module knn_class_tally import knn_pkg::*; #(
    parameter int TYPE_W = TYPE_W_DEF,
    parameter int K      = K_DEF,
    parameter int CW     = $clog2(K + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              upd,
    input  logic [TYPE_W-1:0] upd_type,
    input  logic [CW-1:0]     upd_idx,
    input  logic [TYPE_W-1:0] sc,
    output logic [CW-1:0]     sc_cnt,
    output logic [CW-1:0]     sc_rank
);

    localparam int NUM_CLASSES = 2 ** TYPE_W;
    localparam logic [CW-1:0] K_C = CW'(K);

    logic [CW-1:0] cnt  [NUM_CLASSES];
    logic [CW-1:0] rank [NUM_CLASSES];

    // A rank of K marks a class not yet seen in the current stream.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt[c]  <= '0;
                rank[c] <= K_C;
            end
        end else if (upd) begin
            cnt[upd_type] <= cnt[upd_type] + 1'b1;
            if (rank[upd_type] == K_C) begin
                rank[upd_type] <= upd_idx;
            end
        end
    end

    assign sc_cnt  = cnt[sc];
    assign sc_rank = rank[sc];

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the K nearest beats of a sorted distance stream;
// ties go to the class seen first, result held until consumed.
module knn_vote import knn_pkg::*; #(
    parameter int W      = W_DEF,
    parameter int TYPE_W = TYPE_W_DEF,
    parameter int K      = K_DEF,
    parameter int CW     = $clog2(K + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_dist,
    input  logic [TYPE_W-1:0] in_type,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TYPE_W-1:0] out_class,
    output logic [CW-1:0]     out_votes,
    output logic [W-1:0]      out_min_dist
);

    localparam int NUM_CLASSES = 2 ** TYPE_W;
    localparam logic [CW-1:0]     K_C     = CW'(K);
    localparam logic [TYPE_W-1:0] SC_LAST = TYPE_W'(NUM_CLASSES - 1);

    state_t            state;
    logic [CW-1:0]     idx;
    logic [TYPE_W-1:0] sc;
    logic              scan_en;

    logic [CW-1:0]     cnt_rd;
    logic [CW-1:0]     rank_rd;

    logic [CW-1:0]     cnt_p1;
    logic [CW-1:0]     rank_p1;
    logic [TYPE_W-1:0] class_p1;
    logic              vld_p1;
    logic              last_p1;

    logic [CW-1:0]     best_cnt;
    logic [CW-1:0]     best_rank;
    logic [TYPE_W-1:0] best_class;
    logic [W-1:0]      min_dist;

    logic accept;
    logic counted;
    logic handshake;
    logic stream_end;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == K_C) ? v : v + 1'b1;
    endfunction

    function automatic logic beats_best(
        input logic [CW-1:0] c_cnt,
        input logic [CW-1:0] c_rank,
        input logic [CW-1:0] b_cnt,
        input logic [CW-1:0] b_rank
    );
        return (c_cnt > b_cnt) || ((c_cnt == b_cnt) && (c_rank < b_rank));
    endfunction

    assign accept     = in_valid & in_ready;
    assign counted    = accept & (idx < K_C);
    assign handshake  = out_valid & out_ready;
    assign stream_end = accept & in_last & (state == COLLECT);

    knn_class_tally #(
        .TYPE_W (TYPE_W),
        .K      (K),
        .CW     (CW)
    ) u_tally (
        .clk      (clk),
        .rst      (rst),
        .clr      (handshake),
        .upd      (counted),
        .upd_type (in_type),
        .upd_idx  (idx),
        .sc       (sc),
        .sc_cnt   (cnt_rd),
        .sc_rank  (rank_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx       <= '0;
            sc        <= '0;
            scan_en   <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            vld_p1  <= (state == TALLY) && scan_en;
            last_p1 <= (sc == SC_LAST);
            case (state)
                COLLECT: begin
                    if (accept) begin
                        idx <= sat_inc(idx);
                        if (in_last) begin
                            state    <= TALLY;
                            in_ready <= 1'b0;
                            sc       <= '0;
                            scan_en  <= 1'b1;
                        end
                    end
                end
                TALLY: begin
                    if (scan_en) begin
                        if (sc == SC_LAST) begin
                            scan_en <= 1'b0;
                        end else begin
                            sc <= sc + 1'b1;
                        end
                    end
                    if (vld_p1 && last_p1) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        idx       <= '0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    // p0 -> p1: register the tally read so the compare sees a stable operand.
    always_ff @(posedge clk) begin
        cnt_p1   <= cnt_rd;
        rank_p1  <= rank_rd;
        class_p1 <= sc;
    end

    // p1: compare against the running best; stream end seeds an empty best.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_cnt   <= '0;
            best_rank  <= K_C;
            best_class <= '0;
            min_dist   <= '0;
        end else begin
            if (stream_end) begin
                best_cnt   <= '0;
                best_rank  <= K_C;
                best_class <= '0;
            end else if (vld_p1 && beats_best(cnt_p1, rank_p1, best_cnt, best_rank)) begin
                best_cnt   <= cnt_p1;
                best_rank  <= rank_p1;
                best_class <= class_p1;
            end
            if (accept && (idx == '0)) begin
                min_dist <= in_dist;
            end
        end
    end

    assign out_class    = best_class;
    assign out_votes    = best_cnt;
    assign out_min_dist = min_dist;

endmodule

// File: tb/tb_knn_vote.sv
// Directed vector table plus randomized streams checked against a
// count-and-rank vote model for knn_vote.
module tb_knn_vote;

    localparam int K = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_dist;
    logic [2:0]  in_type;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_class;
    logic [2:0]  out_votes;
    logic [15:0] out_min_dist;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    knn_vote dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dist      (in_dist),
        .in_type      (in_type),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_class    (out_class),
        .out_votes    (out_votes),
        .out_min_dist (out_min_dist)
    );

    typedef struct packed {
        logic [3:0]        n;
        logic [7:0][2:0]   ty;
        logic [7:0][15:0]  ds;
        logic [3:0]        hold;
        logic [2:0]        ec;
        logic [2:0]        ev;
        logic [15:0]       ed;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][2:0] tl(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][2:0] r;
        r[0] = 3'(a0); r[1] = 3'(a1); r[2] = 3'(a2); r[3] = 3'(a3);
        r[4] = 3'(a4); r[5] = 3'(a5); r[6] = 3'(a6); r[7] = 3'(a7);
        return r;
    endfunction

    function automatic logic [7:0][15:0] dl(input int base);
        logic [7:0][15:0] r;
        for (int i = 0; i < 8; i++) r[i] = 16'(base + i);
        return r;
    endfunction

    // Reference: count the first K classes, remember each class's first position,
    // winner has most votes, earliest first position breaks ties.
    function automatic void model(input int n, input logic [7:0][2:0] ty,
                                  input logic [7:0][15:0] ds,
                                  output logic [2:0] c, output logic [2:0] v,
                                  output logic [15:0] d);
        int votes[8];
        int first[8];
        int best;
        for (int k = 0; k < 8; k++) begin
            votes[k] = 0;
            first[k] = 99;
        end
        for (int i = 0; i < n && i < K; i++) begin
            if (votes[ty[i]] == 0) first[ty[i]] = i;
            votes[ty[i]]++;
        end
        best = -1;
        for (int k = 0; k < 8; k++) begin
            if (votes[k] > 0 && (best < 0 || votes[k] > votes[best] ||
                (votes[k] == votes[best] && first[k] < first[best])))
                best = k;
        end
        c = 3'(best);
        v = 3'(votes[best]);
        d = ds[0];
    endfunction

    task automatic beat(input logic [2:0] t, input logic [15:0] d, input logic l, input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_type  = t;
        in_dist  = d;
        in_last  = l;
        @(posedge clk);
    endtask

    task automatic run(input int n, input logic [7:0][2:0] ty, input logic [7:0][15:0] ds,
                       input int hold, input logic [2:0] ec, input logic [2:0] ev,
                       input logic [15:0] ed, input string tag);
        int t;
        int k;
        out_ready = (hold == 0);
        for (int i = 0; i < n; i++) beat(ty[i], ds[i], (i == n - 1), tag);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        t = cyc;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            out_ready = 1'b1;
            return;
        end
        chk({tag, "_latency"}, cyc - t, 9);
        chk({tag, "_class"}, out_class, ec);
        chk({tag, "_votes"}, out_votes, ev);
        chk({tag, "_min_dist"}, out_min_dist, ed);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {out_valid, in_ready, out_class, out_votes, out_min_dist},
                {1'b1, 1'b0, ec, ev, ed});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        logic [2:0]  mc, mv;
        logic [15:0] md;
        logic [7:0][2:0]  rty;
        logic [7:0][15:0] rds;
        int n;
        int base;

        rst = 1'b1;
        in_valid = 1'b0;
        in_dist = '0;
        in_type = '0;
        in_last = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{n: 5, ty: tl(2,2,5,1,2,0,0,0), ds: dl(1),     hold: 0,  ec: 2, ev: 3, ed: 16'd1};
        vecs[1] = '{n: 5, ty: tl(3,4,4,3,6,0,0,0), ds: dl(10),    hold: 0,  ec: 3, ev: 2, ed: 16'd10};
        vecs[2] = '{n: 7, ty: tl(1,1,0,0,0,7,7,0), ds: dl('h100), hold: 0,  ec: 0, ev: 3, ed: 16'h100};
        vecs[3] = '{n: 1, ty: tl(6,0,0,0,0,0,0,0), ds: dl('h40),  hold: 0,  ec: 6, ev: 1, ed: 16'h40};
        vecs[4] = '{n: 4, ty: tl(7,7,2,2,0,0,0,0), ds: dl('h200), hold: 10, ec: 7, ev: 2, ed: 16'h200};
        vecs[5] = '{n: 3, ty: tl(1,4,4,0,0,0,0,0), ds: dl('h300), hold: 0,  ec: 4, ev: 2, ed: 16'h300};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_class", out_class, 0);
        chk("reset_out_votes", out_votes, 0);
        chk("reset_out_min_dist", out_min_dist, 0);

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].n, vecs[i].ty, vecs[i].ds, vecs[i].hold,
                vecs[i].ec, vecs[i].ev, vecs[i].ed, $sformatf("vec%0d", i));
        end

        // Abort a partial stream by reset; nothing from it may survive.
        beat(3'd2, 16'd7, 1'b0, "abort");
        beat(3'd2, 16'd8, 1'b0, "abort");
        beat(3'd2, 16'd9, 1'b0, "abort");
        reset_dut();
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        run(5, tl(5,5,5,5,5,0,0,0), dl(20), 0, 3'd5, 3'd5, 16'd20, "after_abort");
        beat(3'd2, 16'd1, 1'b0, "abort2");
        beat(3'd2, 16'd2, 1'b0, "abort2");
        reset_dut();
        run(2, tl(1,2,0,0,0,0,0,0), dl(30), 0, 3'd1, 3'd1, 16'd30, "tie_after_abort");

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 8);
            base = $urandom_range(0, 60000);
            for (int i = 0; i < 8; i++) begin
                rty[i] = (r < 12) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
                rds[i] = 16'(base + i * 3);
            end
            model(n, rty, rds, mc, mv, md);
            run(n, rty, rds, $urandom_range(0, 2), mc, mv, md, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
